// File: rtl/tick_speed_ctrl.sv
// Game-pacing TICK generator with a speed-up period register and level counter.
// Optional TICK_SIM_FAST_EN shortens the reload count to (PERIOD>>16)-1 for fast simulation.
module tick_speed_ctrl #(
  parameter int CNT_W      = 26,
  parameter int MAX_PERIOD = 12_500_000,
  parameter int MIN_PERIOD = 2_500_000,
  parameter int STEP       = 1_250_000,
  parameter int LVL_W      = 4
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic             EN,
  input  logic             MAXTIME,
  input  logic             SETTIME,
  output logic             TICK,
  output logic [CNT_W-1:0] PERIOD,
  output logic [LVL_W-1:0] LEVEL,
  output logic             AT_MIN
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    HOLD   = 2'd1,
    RELOAD = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] MAX_P  = CNT_W'(MAX_PERIOD);
  localparam logic [CNT_W-1:0] MIN_P  = CNT_W'(MIN_PERIOD);
  localparam logic [CNT_W-1:0] STEP_P = CNT_W'(STEP);
  // One extra bit so MIN_PERIOD+STEP cannot wrap when compared with PERIOD.
  localparam logic [CNT_W:0]   THRESH = (CNT_W+1)'(MIN_PERIOD) + (CNT_W+1)'(STEP);

  state_t           state;
  logic [CNT_W-1:0] cnt;

  function automatic logic [CNT_W-1:0] reload_of(input logic [CNT_W-1:0] p);
`ifdef TICK_SIM_FAST_EN
    logic [CNT_W-1:0] scaled;
    scaled = p >> 16;
    return (scaled == '0) ? '0 : scaled - CNT_W'(1);
`else
    return p - CNT_W'(1);
`endif
  endfunction

  assign AT_MIN = (PERIOD == MIN_P);

  // Commands take priority over counting; RELOAD picks up the freshly updated PERIOD.
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      state  <= RUN;
      PERIOD <= MAX_P;
      cnt    <= reload_of(MAX_P);
      LEVEL  <= '0;
      TICK   <= 1'b0;
    end else begin
      TICK <= 1'b0;
      if (MAXTIME) begin
        PERIOD <= MAX_P;
        LEVEL  <= '0;
        state  <= RELOAD;
      end else if (SETTIME) begin
        if ({1'b0, PERIOD} >= THRESH) PERIOD <= PERIOD - STEP_P;
        else                          PERIOD <= MIN_P;
        if (LEVEL != '1) LEVEL <= LEVEL + LVL_W'(1);
        state <= RELOAD;
      end else if (state == RELOAD) begin
        cnt   <= reload_of(PERIOD);
        state <= EN ? RUN : HOLD;
      end else if (EN) begin
        state <= RUN;
        if (cnt == '0) begin
          cnt  <= reload_of(PERIOD);
          TICK <= 1'b1;
        end else begin
          cnt <= cnt - CNT_W'(1);
        end
      end else begin
        state <= HOLD;
      end
    end
  end

endmodule

// File: tb/tb_tick_speed_ctrl.sv
// Directed bench for tick_speed_ctrl: TICK gaps go through a scoreboard queue, registers checked against a small model.
module tb_tick_speed_ctrl;

  localparam int CNT_W = 8;
  localparam int MAXP  = 10;
  localparam int MINP  = 4;
  localparam int STEP  = 3;
  localparam int LVL_W = 2;

  logic             CLK = 1'b0;
  logic             CLR;
  logic             EN;
  logic             MAXTIME;
  logic             SETTIME;
  logic             TICK;
  logic [CNT_W-1:0] PERIOD;
  logic [LVL_W-1:0] LEVEL;
  logic             AT_MIN;

  tick_speed_ctrl #(
    .CNT_W(CNT_W), .MAX_PERIOD(MAXP), .MIN_PERIOD(MINP), .STEP(STEP), .LVL_W(LVL_W)
  ) dut (
    .CLK(CLK), .CLR(CLR), .EN(EN), .MAXTIME(MAXTIME), .SETTIME(SETTIME),
    .TICK(TICK), .PERIOD(PERIOD), .LEVEL(LEVEL), .AT_MIN(AT_MIN)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    string tag;
    int    gap;
  } exp_t;

  exp_t sbq[$];
  int   errors = 0;
  int   checks = 0;
  int   mPeriod = MAXP;
  int   mLevel  = 0;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic checkRegs(input string tag);
    checkVal({tag, "_period"}, 32'(PERIOD), 32'(mPeriod));
    checkVal({tag, "_level"},  32'(LEVEL),  32'(mLevel));
    checkVal({tag, "_at_min"}, 32'(AT_MIN), (mPeriod == MINP) ? 32'd1 : 32'd0);
  endtask

  task automatic pushGap(input string tag, input int gap);
    exp_t e;
    e.tag = tag;
    e.gap = gap;
    sbq.push_back(e);
  endtask

  // One-cycle command pulse; the model follows the documented period/level rules.
  task automatic applyStimulus(input bit maxt, input bit sett, input bit expectTick, input string tag);
    MAXTIME = maxt;
    SETTIME = sett;
    @(negedge CLK);
    MAXTIME = 1'b0;
    SETTIME = 1'b0;
    if (maxt) begin
      mPeriod = MAXP;
      mLevel  = 0;
    end else if (sett) begin
      mPeriod = (mPeriod >= MINP + STEP) ? mPeriod - STEP : MINP;
      if (mLevel < (1 << LVL_W) - 1) mLevel++;
    end
    checkVal({tag, "_cmd_tick"}, 32'(TICK), 32'd0);
    if (expectTick) pushGap(tag, mPeriod + 1);
  endtask

  task automatic checkOutput();
    int   n;
    bit   seen;
    exp_t e;
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 60) begin
      @(negedge CLK);
      n++;
      if (TICK === 1'b1) seen = 1'b1;
    end
    if (!seen) n = -1;
    if (sbq.size() == 0) begin
      e.tag = "sb_underflow";
      e.gap = -2;
    end else begin
      e = sbq.pop_front();
    end
    checkVal({e.tag, "_gap"}, 32'(n), 32'(e.gap));
  endtask

  task automatic idle(input int n, input string tag);
    int ticks;
    ticks = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      if (TICK !== 1'b0) ticks++;
    end
    checkVal({tag, "_ticks"}, 32'(ticks), 32'd0);
  endtask

  initial begin
    CLR = 1'b1; EN = 1'b1; MAXTIME = 1'b0; SETTIME = 1'b0;
    repeat (2) @(negedge CLK);
    checkRegs("reset");
    checkVal("reset_tick", 32'(TICK), 32'd0);

    // Power-up pacing at the slowest period.
    CLR = 1'b0;
    pushGap("t1_first", MAXP);
    checkOutput();
    pushGap("t1_steady_a", mPeriod);
    checkOutput();
    pushGap("t1_steady_b", mPeriod);
    checkOutput();

    // Speed-ups down to the clamp.
    applyStimulus(1'b0, 1'b1, 1'b1, "t2_set1");
    checkRegs("t2_set1");
    checkOutput();
    pushGap("t2_p7_steady", mPeriod);
    checkOutput();
    applyStimulus(1'b0, 1'b1, 1'b1, "t2_set2");
    checkRegs("t2_set2");
    checkOutput();
    pushGap("t2_p4_steady", mPeriod);
    checkOutput();
    applyStimulus(1'b0, 1'b1, 1'b1, "t2_set3");
    checkRegs("t2_set3");
    checkOutput();

    // Saturated level, then back to slowest.
    applyStimulus(1'b0, 1'b1, 1'b0, "t3_set_sat_a");
    applyStimulus(1'b0, 1'b1, 1'b1, "t3_set_sat_b");
    checkRegs("t3_sat");
    checkOutput();
    applyStimulus(1'b1, 1'b0, 1'b1, "t3_max");
    checkRegs("t3_max");
    checkOutput();

    // MAXTIME beats SETTIME; a command on the cnt==0 cycle swallows that tick.
    applyStimulus(1'b0, 1'b1, 1'b1, "t4_set");
    checkRegs("t4_set");
    checkOutput();
    applyStimulus(1'b1, 1'b1, 1'b1, "t4_both");
    checkRegs("t4_both");
    checkOutput();
    idle(9, "t4_pre_zero");
    applyStimulus(1'b0, 1'b1, 1'b1, "t4_set_on_zero");
    checkRegs("t4_set_on_zero");
    checkOutput();

    // Pause with three counts left, then a held MAXTIME.
    idle(3, "t5_to_cnt3");
    EN = 1'b0;
    idle(25, "t5_paused");
    checkRegs("t5_paused");
    EN = 1'b1;
    pushGap("t5_resume", 4);
    checkOutput();
    MAXTIME = 1'b1;
    idle(30, "t5_max_held");
    applyStimulus(1'b1, 1'b0, 1'b1, "t5_max_release");
    checkRegs("t5_max_release");
    checkOutput();

    // Asynchronous clear while TICK is high at the fastest period.
    applyStimulus(1'b0, 1'b1, 1'b0, "t6_set_a");
    applyStimulus(1'b0, 1'b1, 1'b1, "t6_set_b");
    checkOutput();
    CLR = 1'b1;
    #1;
    mPeriod = MAXP;
    mLevel  = 0;
    checkVal("t6_clr_tick", 32'(TICK), 32'd0);
    checkRegs("t6_clr");
    @(negedge CLK);
    CLR = 1'b0;
    pushGap("t6_after_clr", MAXP);
    checkOutput();

    checkVal("sb_empty", 32'(sbq.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
